mux_nto1_rr: RTL

Parametrised, registered N-to-1 multiplexer for WIDTH-bit data with per-channel valid/ready handshake and two selection modes: fixed select (driven by `sel`) and round-robin arbitration across requesting channels. It replaces ad-hoc combinational select trees wherever several datapath sources share one consumer, such as write-back source selection or shared bus and memory-port sharing. The output is registered, so it also serves as a single-entry pipeline stage.

---
 rtl/mux_nto1_rr.sv | 119 +++++++++++
 1 files changed

// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: registered N-to-1 multiplexer with per-channel valid/ready handshake.
// A channel is picked either by a fixed index or by round-robin search from a rotating pointer.
module mux_nto1_rr #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               rr_en,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load;
    logic             grant_valid;
    logic [SELW-1:0]  grant_idx;
    logic [SELW-1:0]  rr_cand;
    logic [WIDTH-1:0] grant_data;

    // Modulo-N increment; the pointer never leaves 0..N-1, so a single compare suffices.
    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] idx);
        return (idx == SELW'(N - 1)) ? '0 : idx + SELW'(1);
    endfunction

    assign load = !out_valid_q || out_ready;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_cand     = ptr_q;
        if (rr_en) begin
            for (int k = 0; k < N; k++) begin
                if (!grant_valid && in_valid[rr_cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = rr_cand;
                end
                rr_cand = wrap_inc(rr_cand);
            end
        end else begin
            // Out-of-range sel values match no channel and therefore never grant.
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Gated by rst so no source sees an accept while the register is being cleared.
    always_comb begin
        in_ready = '0;
        if (!rst && load && grant_valid) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (grant_valid) begin
                out_data_d  = grant_data;
                out_ch_d    = grant_idx;
                out_valid_d = 1'b1;
                if (rr_en) begin
                    ptr_d = wrap_inc(grant_idx);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data register is reset too, so consumers see a defined zero rather than X after reset.
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
